// File: rtl/pmcc_matrix_readout_pkg.sv
// Shared definitions for the PMC matrix readout path: word width and
// the per-word sample count derived from the lane count.
package pmcc_matrix_readout_pkg;

    localparam int unsigned PMCC_WORD_W = 32;

    function automatic int unsigned pmcc_samples(input int unsigned lanes);
        return PMCC_WORD_W / lanes;
    endfunction

endpackage

// File: rtl/pmcc_matrix_readout_if.sv
// Matrix-side capture controls and bus-side FIFO read port of the readout block.
interface pmcc_matrix_readout_if
    import pmcc_matrix_readout_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 8
);

    logic                            clk_sh;
    logic                            capture_en;
    logic [LANES-1:0]                din;
    logic                            clear;
    logic                            rd_en;
    logic [PMCC_WORD_W-1:0]          rd_data;
    logic                            empty;
    logic                            full;
    logic [$clog2(FIFO_DEPTH):0]     level;
    logic                            overflow;

    modport master (
        output clk_sh, capture_en, din, clear, rd_en,
        input  rd_data, empty, full, level, overflow
    );

    modport slave (
        input  clk_sh, capture_en, din, clear, rd_en,
        output rd_data, empty, full, level, overflow
    );

endinterface

// File: rtl/pmcc_readout_fifo.sv
// Synchronous show-ahead FIFO; a write while full with no simultaneous read
// is dropped and reported on the drop pulse.
module pmcc_readout_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    lvl;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        lvl      = wr_ptr_q - rd_ptr_q;
        empty    = (lvl == '0);
        full     = (lvl == PW'(DEPTH));
        // A pop frees the slot the same-cycle push needs, so full alone does not drop.
        do_pop   = rd_en & ~empty & ~clr;
        do_push  = wr_en & ~clr & (~full | do_pop);
        drop     = wr_en & ~clr & full & ~do_pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level   = lvl;
        rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pmcc_matrix_readout.sv
// Deserialises pixel-matrix serial lines on clk_sh rising edges into 32-bit
// words and queues them for the coprocessor read path.
module pmcc_matrix_readout
    import pmcc_matrix_readout_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmcc_rst_n,
    pmcc_matrix_readout_if.slave  bus
);

    localparam int unsigned W       = PMCC_WORD_W;
    localparam int unsigned SAMPLES = pmcc_samples(LANES);
    localparam int unsigned CNT_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int unsigned SH_W    = (LANES < W) ? (W - LANES) : 1;

    logic             arst_n;
    logic             clk_sh_q, clk_sh_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic             sample;
    logic             push;
    logic             drop;
    logic [W-1:0]     shifted;
    logic [SH_W-1:0]  shreg_next;

    assign arst_n = rst_n & pmcc_rst_n;

    // Only the low W-LANES bits ever reach a future word, so that is all we keep.
    if (LANES < W) begin : g_shift
        assign shifted    = {shreg_q, bus.din};
        assign shreg_next = shifted[SH_W-1:0];
    end else begin : g_wide
        assign shifted    = bus.din;
        assign shreg_next = '0;
    end

    always_comb begin
        clk_sh_d   = bus.clk_sh;
        sample     = bus.clk_sh & ~clk_sh_q & bus.capture_en & ~bus.clear;
        push       = sample && (cnt_q == CNT_W'(SAMPLES - 1));
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | drop;
        if (bus.clear) begin
            shreg_d    = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (sample) begin
            shreg_d = shreg_next;
            cnt_d   = push ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            clk_sh_q   <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            clk_sh_q   <= clk_sh_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;

    pmcc_readout_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (arst_n),
        .clr     (bus.clear),
        .wr_en   (push),
        .wr_data (shifted),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .empty   (bus.empty),
        .full    (bus.full),
        .level   (bus.level),
        .drop    (drop)
    );

endmodule

// File: tb/tb_pmcc_matrix_readout.sv
// Directed bench for pmcc_matrix_readout with a queue-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_pmcc_matrix_readout;

    localparam int LANES   = 4;
    localparam int DEPTH   = 8;
    localparam int SAMPLES = 32 / LANES;

    logic clk;
    logic rst_n;
    logic pmcc_rst_n;

    pmcc_matrix_readout_if #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) bus ();

    pmcc_matrix_readout #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pmcc_rst_n (pmcc_rst_n),
        .bus        (bus)
    );

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: words as plain integers in a queue.
    logic [31:0] mq[$];
    logic [31:0] m_part;
    int          m_cnt;
    logic        m_ovf;
    logic        m_prev;
    bit          m_rise, m_pop, m_was_full;

    always @(posedge clk or negedge rst_n or negedge pmcc_rst_n) begin
        if (!rst_n || !pmcc_rst_n) begin
            mq.delete();
            m_part = 0; m_cnt = 0; m_ovf = 0; m_prev = 0;
        end else begin
            m_rise = bus.clk_sh && !m_prev;
            m_prev = bus.clk_sh;
            if (bus.clear) begin
                mq.delete();
                m_part = 0; m_cnt = 0; m_ovf = 0;
            end else begin
                m_was_full = (mq.size() == DEPTH);
                m_pop = bus.rd_en && (mq.size() > 0);
                if (m_pop) void'(mq.pop_front());
                if (m_rise && bus.capture_en) begin
                    m_part = (m_part << LANES) | 32'(bus.din);
                    m_cnt++;
                    if (m_cnt == SAMPLES) begin
                        if (m_was_full && !m_pop) m_ovf = 1;
                        else mq.push_back(m_part);
                        m_part = 0;
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
        chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
        chk("level",    32'(bus.level),    32'(mq.size()));
        chk("rd_data",  bus.rd_data,       (mq.size() > 0) ? mq[0] : 32'h0);
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [LANES-1:0] d, input logic rd = 1'b0);
        bus.clk_sh = 1'b1; bus.din = d; bus.rd_en = rd;
        cyc();
        bus.rd_en = 1'b0;
        cyc();
        bus.clk_sh = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic push_word(input logic [31:0] w, input logic rd_last = 1'b0);
        for (int i = SAMPLES - 1; i >= 0; i--)
            pulse(w[i*LANES +: LANES], (i == 0) ? rd_last : 1'b0);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pmcc_rst_n = 1'b1;
        bus.clk_sh = 0; bus.capture_en = 1; bus.din = '0; bus.clear = 0; bus.rd_en = 0;
        cyc(); cyc();
        chk("rst_empty",    32'(bus.empty), 32'd1);
        chk("rst_full",     32'(bus.full), 32'd0);
        chk("rst_level",    32'(bus.level), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_rd_data",  bus.rd_data, 32'h0);
        rst_n = 1'b1;
        cyc();

        // 1: basic word, push latency
        for (int i = 1; i <= 7; i++) pulse(LANES'(i));
        bus.clk_sh = 1'b1; bus.din = 4'd8;
        chk("t1_empty_before", 32'(bus.empty), 32'd1);
        cyc();
        chk("t1_empty_after", 32'(bus.empty), 32'd0);
        chk("t1_word",        bus.rd_data, 32'h12345678);
        chk("t1_level",       32'(bus.level), 32'd1);
        cyc(); bus.clk_sh = 1'b0; cyc(); cyc();
        pop();
        chk("t1_drained", 32'(bus.empty), 32'd1);

        // 2: capture pause holds the partial word
        pulse(4'hA); pulse(4'hB); pulse(4'hC);
        bus.capture_en = 1'b0;
        for (int i = 0; i < 5; i++) pulse(4'hF);
        bus.capture_en = 1'b1;
        pulse(4'hD); pulse(4'hE); pulse(4'hF); pulse(4'h0); pulse(4'h1);
        chk("t2_word",  bus.rd_data, 32'hABCDEF01);
        chk("t2_level", 32'(bus.level), 32'd1);
        pop();

        // 3: overfill drops the ninth word
        for (int k = 1; k <= 9; k++) push_word(32'h11111111 * k);
        chk("t3_full",     32'(bus.full), 32'd1);
        chk("t3_level",    32'(bus.level), 32'd8);
        chk("t3_overflow", 32'(bus.overflow), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            chk("t3_order", bus.rd_data, 32'h11111111 * k);
            pop();
        end
        chk("t3_empty", 32'(bus.empty), 32'd1);
        do_clear();
        chk("t3_ovf_cleared", 32'(bus.overflow), 32'd0);

        // 4: push and pop together while full
        for (int k = 1; k <= 8; k++) push_word(32'hA0000000 + k);
        push_word(32'hDEADBEEF, 1'b1);
        chk("t4_overflow", 32'(bus.overflow), 32'd0);
        chk("t4_level",    32'(bus.level), 32'd8);
        for (int k = 2; k <= 8; k++) begin
            chk("t4_order", bus.rd_data, 32'hA0000000 + k);
            pop();
        end
        chk("t4_tail", bus.rd_data, 32'hDEADBEEF);
        pop();

        // 5: clear flushes words and pending samples, suppresses a same-cycle sample
        push_word(32'h01234567);
        push_word(32'h89ABCDEF);
        for (int i = 1; i <= 5; i++) pulse(LANES'(i));
        bus.clk_sh = 1'b1; bus.din = 4'h6; bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        cyc(); bus.clk_sh = 1'b0; cyc(); cyc();
        chk("t5_empty",    32'(bus.empty), 32'd1);
        chk("t5_level",    32'(bus.level), 32'd0);
        chk("t5_overflow", 32'(bus.overflow), 32'd0);
        push_word(32'hCAFEF00D);
        chk("t5_clean_word", bus.rd_data, 32'hCAFEF00D);
        chk("t5_level1",     32'(bus.level), 32'd1);
        pop();

        // 6: coprocessor reset mid-word, asynchronous
        push_word(32'h11223344);
        push_word(32'h55667788);
        push_word(32'h99AABBCC);
        pulse(4'h1); pulse(4'h2); pulse(4'h3);
        chk("t6_level_pre", 32'(bus.level), 32'd3);
        #1 pmcc_rst_n = 1'b0;
        #1;
        chk("t6_empty",    32'(bus.empty), 32'd1);
        chk("t6_level",    32'(bus.level), 32'd0);
        chk("t6_full",     32'(bus.full), 32'd0);
        chk("t6_overflow", 32'(bus.overflow), 32'd0);
        chk("t6_rd_data",  bus.rd_data, 32'h0);
        cyc();
        pmcc_rst_n = 1'b1;
        cyc();
        pop();
        chk("t6_rd_empty_level", 32'(bus.level), 32'd0);
        chk("t6_rd_empty_flag",  32'(bus.empty), 32'd1);
        push_word(32'h13579BDF);
        chk("t6_clean_word", bus.rd_data, 32'h13579BDF);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmcc_matrix_readout.md
Name: pmcc_matrix_readout

Overview:
Downstream companion of the PMC coprocessor matrix controller. It observes the matrix shift clock (clk_sh) driven by the controller and deserialises the pixel-matrix serial outputs into 32-bit words. Words are buffered in a small FIFO that the coprocessor/bus side drains. Sits between the pixel-matrix data outputs and the PMC coprocessor read path.

Parameters:
LANES, 4, number of parallel matrix serial data lines sampled per clk_sh rising edge; must divide 32 (1, 2, 4, 8, 16, 32)
FIFO_DEPTH, 8, FIFO word capacity; power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
pmcc_rst_n  input  1  coprocessor reset, asynchronous, active-low; same effect as rst_n
clk_sh  input  1  matrix shift clock, a clk-synchronous register output of the matrix controller
capture_en  input  1  enables sampling on clk_sh rising edges
din  input  LANES  matrix serial data lines
clear  input  1  synchronous flush: partial word, FIFO, overflow
rd_en  input  1  pop request
rd_data  output  32  FIFO head word (show-ahead)
empty  output  1  FIFO empty
full  output  1  FIFO full
level  output  $clog2(FIFO_DEPTH)+1  words stored
overflow  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (either reset low): clk_sh_q=0, shift register=0, sample counter=0, FIFO pointers=0, rd_data=0, empty=1, full=0, level=0, overflow=0.
- Edge detect: clk_sh_q registers clk_sh every cycle. sample = clk_sh & ~clk_sh_q & capture_en & ~clear.
- Sampling and word assembly:
  - SAMPLES = 32/LANES.
  - On each sample, the word shifts left by LANES and din enters the LSBs.
  - The first sample of a word ends in bits [31:32-LANES]. din[LANES-1] maps to the higher bit.
  - Counter runs 0..SAMPLES-1 and wraps to 0 on the completing sample.
- Push:
  - On the edge where sample occurs with counter==SAMPLES-1, the word {shreg[31-LANES:0], din} is written to the FIFO on that same edge.
  - empty deasserts after that edge (1-cycle latency from the completing clk_sh rising edge being seen).
- capture_en low: clk_sh edges are ignored. A partial word and the counter are held, not discarded.
- Pop: rd_en with !empty advances the head on the clock edge. rd_data is combinational from the head entry. rd_en while empty is ignored, with no pointer change.
- FIFO boundary cases:
  - Push while full and no pop: word dropped, overflow<=1, FIFO unchanged.
  - Push and pop in the same cycle while full: both performed, level unchanged, no overflow.
  - Push and pop in the same cycle while empty: only the push is performed; the rd_en is ignored.
  - full = (level==FIFO_DEPTH); empty = (level==0).
- clear (synchronous, one cycle):
  - counter=0, shift register=0, FIFO pointers=0, overflow=0.
  - Any sample or push in the same cycle is suppressed.
  - clk_sh_q still updates.
- overflow stays set until clear or reset.
- Reset mid-word or mid-FIFO: all state discarded immediately (asynchronous).
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide with natural wrap. level = wr_ptr - rd_ptr.

Decomposition:
- The shared pmcc package holds PMCC_WORD_W=32 and a function computing SAMPLES from LANES.
- One sub-module, pmcc_readout_fifo: synchronous show-ahead FIFO.
  - Inputs: clk, rst_n, clr, wr_en, wr_data, rd_en.
  - Outputs: rd_data, empty, full, level, and a drop pulse that feeds the overflow flag.
- Edge detect, shift register and counter live in the top module.

Test Plan:
1. LANES=4: 8 clk_sh pulses (2 cycles high, 2 low) with din=1,2,…,8 on the rising edges -> rd_data=0x12345678, level=1, empty low one cycle after the 8th rising edge is seen.
2. Pause mid-word: 3 samples (din=A,B,C), capture_en=0 for 5 clk_sh pulses, re-enable, 5 samples (din=D,E,F,0,1) -> single word 0xABCDEF01; the ignored pulses add nothing.
3. Fill: 9 words with no reads (FIFO_DEPTH=8) -> full=1, level=8, overflow=1; the ninth word is absent; reads return words 1..8 in order, then empty=1.
4. Full with rd_en asserted on the completing edge of word 9 -> no overflow, level stays 8, word 9 present at the tail.
5. clear with 2 words stored plus 5 pending samples -> empty=1, level=0, overflow=0; the next 8 samples form a clean word.
6. pmcc_rst_n pulse low mid-word with 3 words queued -> all outputs return to reset values asynchronously; rd_en while empty leaves level=0.
